// File: rtl/dec_pkg.sv
// Shared definitions for the pulsed 2-to-4 decoder: FSM state encoding and
// the width of the hold/gap counter.
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int CNT_W = 8;

endpackage : dec_pkg

// File: rtl/dec2_4_core.sv
// Pure combinational 2-to-4 one-hot decode; the parent registers the result.
module dec2_4_core (
    input  logic [1:0] a,
    output logic [3:0] y
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            assign y[gi] = (a == 2'(gi));
        end
    endgenerate

endmodule : dec2_4_core

// File: rtl/dec2_4_pulse.sv
// Accepts a 2-bit code, drives the decoded one-hot line for HOLD_CYCLES
// cycles, then idles for GAP_CYCLES cycles before accepting the next code.
module dec2_4_pulse
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] a,
    output logic [3:0] y,
    output logic       busy,
    output logic       done
);

    localparam int             GAP_M1    = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_M1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_code;
    logic [3:0]       r_y;
    logic             r_done;

    logic             w_accept;
    logic [1:0]       w_code_sel;
    logic [3:0]       w_dec;

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    // Decode the incoming code on the accepting edge so y is valid one cycle later.
    assign w_code_sel = w_accept ? a : r_code;

    dec2_4_core u_core (
        .a (w_code_sel),
        .y (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= 2'b00;
            r_y     <= 4'b0000;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_DRIVE;
                        r_cnt   <= HOLD_LOAD;
                        r_code  <= a;
                        r_y     <= w_dec;
                        r_done  <= (HOLD_LOAD == '0);
                    end else begin
                        r_y    <= 4'b0000;
                        r_done <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_y    <= w_dec;
                        r_done <= (r_cnt == CNT_W'(1));
                    end else begin
                        r_y    <= 4'b0000;
                        r_done <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= ST_GAP;
                            r_cnt   <= GAP_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    r_y    <= 4'b0000;
                    r_done <= 1'b0;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_y     <= 4'b0000;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign y        = r_y;
    assign done     = r_done;

endmodule : dec2_4_pulse

// File: tb/tb_dec2_4_pulse.sv
// Table-driven bench for dec2_4_pulse: default HOLD=4/GAP=1 instance plus a
// HOLD=1/GAP=0 instance, expected outputs queued per edge and checked after it.
module tb_dec2_4_pulse;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] a;
        logic [3:0] y;
        logic       done;
        logic       busy;
        logic       ready;
    } vec_t;

    typedef struct {
        logic [3:0] y;
        logic       done;
        logic       busy;
        logic       ready;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, v_a = 1'b0;
    logic [1:0] a_a = 2'b00;
    logic       rdy_a, busy_a, done_a;
    logic [3:0] y_a;

    logic       rst_b = 1'b1, v_b = 1'b0;
    logic [1:0] a_b = 2'b00;
    logic       rdy_b, busy_b, done_b;
    logic [3:0] y_b;

    dec2_4_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(v_a), .in_ready(rdy_a),
        .a(a_a), .y(y_a), .busy(busy_a), .done(done_a)
    );

    dec2_4_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(v_b), .in_ready(rdy_b),
        .a(a_b), .y(y_b), .busy(busy_b), .done(done_b)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] a,
                                input logic [3:0] y, input logic d, input logic b,
                                input logic rd);
        vec_t t;
        t.rst = r; t.v = v; t.a = a; t.y = y; t.done = d; t.busy = b; t.ready = rd;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, got, want);
        end
    endtask

    task automatic run_vec(input int inst, input int idx, input vec_t t);
        exp_t e;
        logic [3:0] gy;
        logic gd, gb, gr;
        @(negedge clk);
        if (inst == 0) begin
            rst_a = t.rst; v_a = t.v; a_a = t.a;
        end else begin
            rst_b = t.rst; v_b = t.v; a_b = t.a;
        end
        e.y = t.y; e.done = t.done; e.busy = t.busy; e.ready = t.ready;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (inst == 0) begin
            gy = y_a; gd = done_a; gb = busy_a; gr = rdy_a;
        end else begin
            gy = y_b; gd = done_b; gb = busy_b; gr = rdy_b;
        end
        $display("inst=%0d vec=%0d rst=%b v=%b a=%0d -> y=%b done=%b busy=%b ready=%b",
                 inst, idx, t.rst, t.v, t.a, gy, gd, gb, gr);
        chk("y", idx, gy, e.y);
        chk("done", idx, {3'b0, gd}, {3'b0, e.done});
        chk("busy", idx, {3'b0, gb}, {3'b0, e.busy});
        chk("in_ready", idx, {3'b0, gr}, {3'b0, e.ready});
        chk("onehot", idx, {3'b0, ($countones(gy) <= 1)}, 4'd1);
    endtask

    initial begin
        // Reset, then a single pulse of code 2.
        tbl.push_back(mk(1, 0, 2'd0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 2'd0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2'd2, 4'b0100, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0100, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0100, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0100, 1, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0000, 0, 0, 1));
        // Code changed mid-DRIVE must be ignored.
        tbl.push_back(mk(0, 1, 2'd1, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2'd3, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2'd3, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2'd3, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 0, 2'd3, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0000, 0, 0, 1));
        // Reset during the second DRIVE cycle aborts without done.
        tbl.push_back(mk(0, 1, 2'd0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(1, 0, 2'd0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'd0, 4'b0000, 0, 0, 1));
        // Reset wins over a simultaneous handshake.
        tbl.push_back(mk(1, 1, 2'd3, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'd3, 4'b0000, 0, 0, 1));
        // Back-to-back codes 0..3 with in_valid held high.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << k;
            tbl.push_back(mk(0, 1, 2'(k), oh, 0, 1, 0));
            tbl.push_back(mk(0, 1, 2'(k), oh, 0, 1, 0));
            tbl.push_back(mk(0, 1, 2'(k), oh, 0, 1, 0));
            tbl.push_back(mk(0, 1, 2'(k), oh, 1, 1, 0));
            tbl.push_back(mk(0, 1, 2'(k + 1), 4'b0000, 0, 1, 0));
            tbl.push_back(mk(0, (k != 3), 2'(k + 1), 4'b0000, 0, 0, 1));
        end

        for (int i = 0; i < tbl.size(); i++) run_vec(0, i, tbl[i]);

        // HOLD=1, GAP=0: single-cycle pulses with done in the same cycle.
        run_vec(1, 100, mk(1, 0, 2'd0, 4'b0000, 0, 0, 1));
        run_vec(1, 101, mk(0, 1, 2'd3, 4'b1000, 1, 1, 0));
        run_vec(1, 102, mk(0, 0, 2'd0, 4'b0000, 0, 0, 1));
        run_vec(1, 103, mk(0, 1, 2'd1, 4'b0010, 1, 1, 0));
        run_vec(1, 104, mk(0, 1, 2'd2, 4'b0000, 0, 0, 1));
        run_vec(1, 105, mk(0, 1, 2'd2, 4'b0100, 1, 1, 0));
        run_vec(1, 106, mk(0, 0, 2'd0, 4'b0000, 0, 0, 1));

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dec2_4_pulse
